sirv_pwmcap16_core: RTL and testbench
=====================================

// Module: sirv_pwmcap16_core
// PURPOSE
//  Input-capture counterpart of the PWM16 generator: measures period and high time of an external PWM
//  waveform on one GPIO pin. Sits behind the same TileLink register-router shim as the PWM core
//  (write_valid/write_bits/read triplets). Flags capture-done and overflow interrupts to the PLIC.
// PARAMETERS
//  SYNC_STAGES  2   metastability flops on io_pin (>=2)
// PORTS
//  clock                        in   1   core clock
//  reset                        in   1   asynchronous, active-high; all flops cleared
//  io_pin                       in   1   raw PWM input, asynchronous to clock
//  io_regs_cfg_write_valid      in   1   cfg register write strobe
//  io_regs_cfg_write_bits       in   32  cfg write data
//  io_regs_cfg_read             out  32  cfg readback
//  io_regs_period_read          out  16  last captured period (scaled ticks)
//  io_regs_high_read            out  16  last captured high time (scaled ticks)
//  io_regs_status_read          out  32  {14'h0, state[1:0], cnt[15:0]}
//  io_ip_0                      out  1   capture-done pending (sticky)
//  io_ip_1                      out  1   overflow pending (sticky)
// BEHAVIOUR
//  cfg: [3:0] scale, [8] pol (1 = invert pin), [12] enAlways, [13] enOneShot, [28] ip_cap, [29] ip_ovf;
//   all other bits read 0. A cfg write loads every field, incl. ip bits (SW clears ip by writing 0).
//  Reset: all outputs 0; state IDLE; cnt, pre, period, high, high_tmp, sync flops = 0.
//  p = sync(io_pin) ^ pol; p_d = p delayed 1 clk (always updated); rise = p&~p_d, fall = ~p&p_d.
//  en = enAlways | enOneShot. pre: 15-bit, +1 every clk while en; tick = &pre[scale-1:0] (scale=0: every clk).
//  cnt: 16-bit, +1 on tick in HIGH/LOW. capv = (cnt==16'hFFFF) ? 16'hFFFF : cnt + tick.
//  FSM (2-bit): IDLE=0, HIGH=1, LOW=2.
//   IDLE: cnt,pre held 0. en & rise -> HIGH, cnt<=0, pre<=0.
//   HIGH: fall -> high_tmp<=capv, LOW (cnt keeps counting, not cleared).
//   LOW:  rise -> period<=capv, high<=high_tmp, ip_cap<=1, cnt<=0, pre<=0;
//         enOneShot&~enAlways -> enOneShot<=0, IDLE; else HIGH.
//   HIGH/LOW: cnt==FFFF & tick & no qualifying edge -> ip_ovf<=1, enOneShot<=0, IDLE.
//   ~en in any state -> IDLE next clk; no capture, no ip change.
//  Latency: pin edge to ip_cap = SYNC_STAGES+1 clks (sync + edge-detect register).
//  Priority: cfg write > edge > overflow. Write in the same clk as a completing edge: period/high
//   unchanged, ip = written bits, state IDLE, cnt=pre=0 (cfg write always restarts measurement).
//  period/high update atomically in the same clk; stable until the next capture.
//  Glitch shorter than one clk may be lost by sync; not a requirement to catch.
//  Reset asserted mid-measurement: immediate IDLE, captures lost, ip cleared.
// STRUCTURE
//  sirv_pwmcap_pkg: FSM state localparams, cfg bit positions (shared with driver header gen).
//  Sub-module sirv_pwmcap_sync: SYNC_STAGES flop chain, async active-high reset to 0.
//  Core: edge detect, prescaler, counter, FSM, capture regs in one always block set.
// TESTING
//  scale=0, enAlways, pin 10 high / 30 low clks -> period=40, high=10, io_ip_0=1 at 2nd rise+3 clks.
//  scale=2, pin 40 high / 40 low -> period=20, high=10; pol=1 same stimulus -> high=10 (phases swap).
//  enOneShot only, continuous PWM -> exactly one capture, cfg[13] reads 0 after, state IDLE.
//  scale=0, pin held high after first rise -> ip_ovf=1 after 65536 clks, state IDLE, period unchanged.
//  cfg write (ip bits 0) in same clk as completing rise -> ip_cap=0, period old value, state IDLE.
//  reset pulse mid-LOW -> all reads 0, next full cycle captured correctly after re-enable.

Source files
------------

// File: rtl/sirv_pwmcap16_core_pkg.sv
// Shared definitions for the PWM input-capture core: FSM states, cfg field
// positions and the packing helpers used by the register readback.
package sirv_pwmcap16_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } cap_state_e;

    localparam int CFG_SCALE_LSB   = 0;
    localparam int CFG_SCALE_W     = 4;
    localparam int CFG_POL_BIT     = 8;
    localparam int CFG_ALWAYS_BIT  = 12;
    localparam int CFG_ONESHOT_BIT = 13;
    localparam int CFG_IPCAP_BIT   = 28;
    localparam int CFG_IPOVF_BIT   = 29;

    typedef struct packed {
        logic       ip_ovf;
        logic       ip_cap;
        logic       en_oneshot;
        logic       en_always;
        logic       pol;
        logic [3:0] scale;
    } cfg_t;

    function automatic logic [31:0] cfg_pack(input cfg_t c);
        logic [31:0] w;
        w = '0;
        w[CFG_SCALE_LSB +: CFG_SCALE_W] = c.scale;
        w[CFG_POL_BIT]                  = c.pol;
        w[CFG_ALWAYS_BIT]               = c.en_always;
        w[CFG_ONESHOT_BIT]              = c.en_oneshot;
        w[CFG_IPCAP_BIT]                = c.ip_cap;
        w[CFG_IPOVF_BIT]                = c.ip_ovf;
        return w;
    endfunction

    function automatic cfg_t cfg_unpack(input logic [31:0] w);
        cfg_t c;
        c.scale      = w[CFG_SCALE_LSB +: CFG_SCALE_W];
        c.pol        = w[CFG_POL_BIT];
        c.en_always  = w[CFG_ALWAYS_BIT];
        c.en_oneshot = w[CFG_ONESHOT_BIT];
        c.ip_cap     = w[CFG_IPCAP_BIT];
        c.ip_ovf     = w[CFG_IPOVF_BIT];
        return c;
    endfunction

    // Tick when the low 'scale' prescaler bits are all ones; scale 0 ticks every clock.
    function automatic logic pre_tick(input logic [14:0] pre, input logic [3:0] scale);
        logic [15:0] mask;
        mask = (16'd1 << scale) - 16'd1;
        return (({1'b0, pre} & mask) == mask);
    endfunction

endpackage

// File: rtl/sirv_pwmcap16_core_if.sv
// Register-router shim bundle of the capture core: cfg write triplet and
// the read-only measurement registers.
interface sirv_pwmcap16_core_if;
    logic        io_regs_cfg_write_valid;
    logic [31:0] io_regs_cfg_write_bits;
    logic [31:0] io_regs_cfg_read;
    logic [15:0] io_regs_period_read;
    logic [15:0] io_regs_high_read;
    logic [31:0] io_regs_status_read;

    modport master (
        output io_regs_cfg_write_valid,
        output io_regs_cfg_write_bits,
        input  io_regs_cfg_read,
        input  io_regs_period_read,
        input  io_regs_high_read,
        input  io_regs_status_read
    );

    modport slave (
        input  io_regs_cfg_write_valid,
        input  io_regs_cfg_write_bits,
        output io_regs_cfg_read,
        output io_regs_period_read,
        output io_regs_high_read,
        output io_regs_status_read
    );
endinterface

// File: rtl/sirv_pwmcap16_core_sync.sv
// Metastability flop chain for the asynchronous PWM input pin.
module sirv_pwmcap16_core_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sirv_pwmcap16_core.sv
// PWM input capture: measures period and high time of the synchronised pin
// in prescaled ticks and raises sticky capture-done / overflow pending bits.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | disabled or waiting for the first rising edge; cnt/pre at 0
//   ST_HIGH | pin high phase, counting towards the falling edge
//   ST_LOW  | pin low phase, counting towards the period-closing rise
module sirv_pwmcap16_core
    import sirv_pwmcap16_core_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_pin,
    sirv_pwmcap16_core_if.slave        regs,
    output logic                       io_ip_0,
    output logic                       io_ip_1
);

    cap_state_e  state_q, state_d;
    cfg_t        cfg_q, cfg_d;
    logic [15:0] cnt_q, cnt_d;
    logic [14:0] pre_q, pre_d;
    logic [15:0] period_q, period_d;
    logic [15:0] high_q, high_d;
    logic [15:0] high_tmp_q, high_tmp_d;
    logic        p_prev_q;

    logic        pin_sync;
    logic        p;
    logic        rise;
    logic        fall;
    logic        en;
    logic        tick;
    logic        cnt_top;
    logic [15:0] capv;

    sirv_pwmcap16_core_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (io_pin),
        .q_o   (pin_sync)
    );

    always_comb begin
        p       = pin_sync ^ cfg_q.pol;
        rise    = p & ~p_prev_q;
        fall    = ~p & p_prev_q;
        en      = cfg_q.en_always | cfg_q.en_oneshot;
        tick    = pre_tick(pre_q, cfg_q.scale);
        cnt_top = (cnt_q == 16'hFFFF) & tick;
        capv    = (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + {15'd0, tick};
    end

    always_comb begin
        cfg_d      = cfg_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        period_d   = period_q;
        high_d     = high_q;
        high_tmp_d = high_tmp_q;

        if (regs.io_regs_cfg_write_valid) begin
            // A cfg write always restarts measurement and overrides any same-cycle edge.
            cfg_d   = cfg_unpack(regs.io_regs_cfg_write_bits);
            state_d = ST_IDLE;
            cnt_d   = '0;
            pre_d   = '0;
        end else if (!en || state_q == ST_IDLE) begin
            cnt_d   = '0;
            pre_d   = '0;
            state_d = (en && rise) ? ST_HIGH : ST_IDLE;
        end else begin
            pre_d = pre_q + 15'd1;
            cnt_d = capv;
            case (state_q)
                ST_HIGH: begin
                    if (fall) begin
                        high_tmp_d = capv;
                        state_d    = ST_LOW;
                    end else if (cnt_top) begin
                        cfg_d.ip_ovf     = 1'b1;
                        cfg_d.en_oneshot = 1'b0;
                        state_d          = ST_IDLE;
                        cnt_d            = '0;
                        pre_d            = '0;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_d     = capv;
                        high_d       = high_tmp_q;
                        cfg_d.ip_cap = 1'b1;
                        cnt_d        = '0;
                        pre_d        = '0;
                        if (cfg_q.en_oneshot && !cfg_q.en_always) begin
                            cfg_d.en_oneshot = 1'b0;
                            state_d          = ST_IDLE;
                        end else begin
                            state_d = ST_HIGH;
                        end
                    end else if (cnt_top) begin
                        cfg_d.ip_ovf     = 1'b1;
                        cfg_d.en_oneshot = 1'b0;
                        state_d          = ST_IDLE;
                        cnt_d            = '0;
                        pre_d            = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pre_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            period_q   <= '0;
            high_q     <= '0;
            high_tmp_q <= '0;
            p_prev_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            period_q   <= period_d;
            high_q     <= high_d;
            high_tmp_q <= high_tmp_d;
            p_prev_q   <= p;
        end
    end

    assign regs.io_regs_cfg_read    = cfg_pack(cfg_q);
    assign regs.io_regs_period_read = period_q;
    assign regs.io_regs_high_read   = high_q;
    assign regs.io_regs_status_read = {14'h0, state_q, cnt_q};
    assign io_ip_0                  = cfg_q.ip_cap;
    assign io_ip_1                  = cfg_q.ip_ovf;

endmodule

// File: tb/tb_sirv_pwmcap16_core.sv
// Bench for the PWM capture core: directed scenarios plus randomized PWM
// shapes checked against a tick-arithmetic reference model.
module tb_sirv_pwmcap16_core;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic io_pin = 1'b0;
    logic io_ip_0;
    logic io_ip_1;

    int n_tests = 0;
    int n_fail  = 0;

    sirv_pwmcap16_core_if regs_if();

    sirv_pwmcap16_core #(
        .SYNC_STAGES (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .io_pin  (io_pin),
        .regs    (regs_if),
        .io_ip_0 (io_ip_0),
        .io_ip_1 (io_ip_1)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [31:0] v);
        regs_if.io_regs_cfg_write_valid = 1'b1;
        regs_if.io_regs_cfg_write_bits  = v;
        step(1);
        regs_if.io_regs_cfg_write_valid = 1'b0;
        regs_if.io_regs_cfg_write_bits  = 32'h0;
    endtask

    function automatic logic [31:0] mk_cfg(input int scale, input int pol, input int al,
                                           input int os, input int ipc, input int ipo);
        return 32'(scale) + 32'(pol) * 32'd256 + 32'(al) * 32'd4096 + 32'(os) * 32'd8192
             + 32'(ipc) * 32'h1000_0000 + 32'(ipo) * 32'h2000_0000;
    endfunction

    // Reference: a phase of n clocks holds floor(n / 2^scale) prescaled ticks, saturating.
    function automatic logic [31:0] scaled(input int n, input int s);
        int v;
        v = n / (1 << s);
        return (v > 65535) ? 32'hFFFF : 32'(v);
    endfunction

    // Quiesce, park the pin at its logical-low level, then apply the new cfg.
    task automatic setup(input logic [31:0] cfg, input int pol);
        cfg_write(32'h0);
        io_pin = pol[0];
        step(4);
        cfg_write(cfg);
        step(2);
    endtask

    task automatic run_p(input int pol, input int h, input int l);
        io_pin = ~pol[0];
        step(h);
        io_pin = pol[0];
        step(l);
    endtask

    function automatic logic [31:0] st(input logic [31:0] status);
        return {30'h0, status[17:16]};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, pol, h, l;
        regs_if.io_regs_cfg_write_valid = 1'b0;
        regs_if.io_regs_cfg_write_bits  = 32'h0;

        step(3);
        check_val("rst_cfg",    regs_if.io_regs_cfg_read, 32'h0);
        check_val("rst_period", 32'(regs_if.io_regs_period_read), 32'h0);
        check_val("rst_high",   32'(regs_if.io_regs_high_read), 32'h0);
        check_val("rst_status", regs_if.io_regs_status_read, 32'h0);
        check_val("rst_ip",     {30'h0, io_ip_1, io_ip_0}, 32'h0);
        reset = 1'b0;
        step(2);

        // scale 0, 10 high / 30 low, interrupt latency from the second rise
        setup(mk_cfg(0, 0, 1, 0, 0, 0), 0);
        check_val("t1_cfg", regs_if.io_regs_cfg_read, mk_cfg(0, 0, 1, 0, 0, 0));
        run_p(0, 10, 30);
        io_pin = 1'b1;
        step(2);
        check_val("t1_ip_early", {31'h0, io_ip_0}, 32'h0);
        step(1);
        check_val("t1_ip_lat", {31'h0, io_ip_0}, 32'h1);
        check_val("t1_period", 32'(regs_if.io_regs_period_read), scaled(40, 0));
        check_val("t1_high",   32'(regs_if.io_regs_high_read), scaled(10, 0));
        check_val("t1_state",  st(regs_if.io_regs_status_read), 32'h1);

        // scale 2, 40/40, then inverted polarity
        setup(mk_cfg(2, 0, 1, 0, 0, 0), 0);
        run_p(0, 40, 40);
        io_pin = 1'b1;
        step(4);
        check_val("t2_period", 32'(regs_if.io_regs_period_read), scaled(80, 2));
        check_val("t2_high",   32'(regs_if.io_regs_high_read), scaled(40, 2));
        setup(mk_cfg(2, 1, 1, 0, 0, 0), 1);
        run_p(1, 40, 40);
        io_pin = 1'b0;
        step(4);
        check_val("t2p_period", 32'(regs_if.io_regs_period_read), scaled(80, 2));
        check_val("t2p_high",   32'(regs_if.io_regs_high_read), scaled(40, 2));
        check_val("t2p_ip",     {31'h0, io_ip_0}, 32'h1);

        // one-shot: only the first full period is captured
        setup(mk_cfg(0, 0, 0, 1, 0, 0), 0);
        run_p(0, 10, 10);
        run_p(0, 6, 6);
        io_pin = 1'b1;
        step(4);
        check_val("t3_period", 32'(regs_if.io_regs_period_read), scaled(20, 0));
        check_val("t3_high",   32'(regs_if.io_regs_high_read), scaled(10, 0));
        check_val("t3_cfg",    regs_if.io_regs_cfg_read, mk_cfg(0, 0, 0, 0, 1, 0));
        check_val("t3_state",  st(regs_if.io_regs_status_read), 32'h0);

        // overflow: pin stuck high after the first rise
        setup(mk_cfg(0, 0, 1, 0, 0, 0), 0);
        io_pin = 1'b1;
        step(103);
        check_val("t4_cnt", regs_if.io_regs_status_read, {14'h0, 2'd1, 16'd100});
        step(65538 - 103);
        check_val("t4_ovf_early", {31'h0, io_ip_1}, 32'h0);
        step(1);
        check_val("t4_ovf",    {31'h0, io_ip_1}, 32'h1);
        check_val("t4_status", regs_if.io_regs_status_read, 32'h0);
        check_val("t4_period", 32'(regs_if.io_regs_period_read), scaled(20, 0));
        check_val("t4_cfg",    regs_if.io_regs_cfg_read, mk_cfg(0, 0, 1, 0, 0, 1));

        // cfg write coinciding with the period-closing rise
        setup(mk_cfg(0, 0, 1, 0, 0, 0), 0);
        run_p(0, 14, 9);
        io_pin = 1'b1;
        step(2);
        cfg_write(mk_cfg(0, 0, 1, 0, 0, 0));
        check_val("t5_ip",     {31'h0, io_ip_0}, 32'h0);
        check_val("t5_period", 32'(regs_if.io_regs_period_read), scaled(20, 0));
        check_val("t5_high",   32'(regs_if.io_regs_high_read), scaled(10, 0));
        check_val("t5_status", regs_if.io_regs_status_read, 32'h0);

        // asynchronous reset during the low phase, then a clean capture
        setup(mk_cfg(0, 0, 1, 0, 0, 0), 0);
        io_pin = 1'b1;
        step(12);
        io_pin = 1'b0;
        step(6);
        check_val("t6_pre_state", st(regs_if.io_regs_status_read), 32'h2);
        #2 reset = 1'b1;
        #1;
        check_val("t6_cfg",    regs_if.io_regs_cfg_read, 32'h0);
        check_val("t6_period", 32'(regs_if.io_regs_period_read), 32'h0);
        check_val("t6_status", regs_if.io_regs_status_read, 32'h0);
        step(2);
        reset = 1'b0;
        step(1);
        setup(mk_cfg(0, 0, 1, 0, 0, 0), 0);
        run_p(0, 12, 8);
        io_pin = 1'b1;
        step(4);
        check_val("t6_new_period", 32'(regs_if.io_regs_period_read), scaled(20, 0));
        check_val("t6_new_high",   32'(regs_if.io_regs_high_read), scaled(12, 0));
        check_val("t6_new_ip",     {31'h0, io_ip_0}, 32'h1);

        // randomized shapes, scales and polarity
        for (int i = 0; i < 12; i++) begin
            s   = int'($urandom_range(0, 3));
            pol = int'($urandom_range(0, 1));
            h   = int'($urandom_range(2, 50));
            l   = int'($urandom_range(2, 50));
            setup(mk_cfg(s, pol, 1, 0, 0, 0), pol);
            run_p(pol, h, l);
            run_p(pol, h, l);
            io_pin = ~pol[0];
            step(4);
            check_val($sformatf("rnd%0d_period", i), 32'(regs_if.io_regs_period_read), scaled(h + l, s));
            check_val($sformatf("rnd%0d_high", i),   32'(regs_if.io_regs_high_read), scaled(h, s));
            check_val($sformatf("rnd%0d_cfg", i),    regs_if.io_regs_cfg_read, mk_cfg(s, pol, 1, 0, 1, 0));
            check_val($sformatf("rnd%0d_state", i),  st(regs_if.io_regs_status_read), 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
